// File: rtl/clk_divider_bank.sv
// Bank of independent runtime-programmable clock dividers with glitch-free divisor changeover.
// Outputs are registered (one edge from inputs); there is no backpressure, and writes are accepted or flagged via wr_err.
module clk_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 100_000,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              wr_err
);

  localparam logic [CNT_W-1:0] DEF_P      = CNT_W'(DEFAULT_DIV);
  localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W+1)'(NUM_CH);

  logic wr_ok;

  // Selector is widened by one bit so the range check stays meaningful for power-of-two banks.
  assign wr_ok = div_wr && (div_data >= CNT_W'(2)) && ({1'b0, div_sel} < NUM_CH_EXT);

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= div_wr && !wr_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] ctr;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] per_n;
    logic [CNT_W-1:0] hi_len;
    logic             pf;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;

    assign hi_len = per - (per >> 1);
    assign wr_hit = wr_ok && (div_sel == SEL_W'(i));

    always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
        ctr    <= '0;
        per    <= DEF_P;
        per_n  <= DEF_P;
        pf     <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (!ch_en[i]) begin
          ctr    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pf) begin
            per <= per_n;
            pf  <= 1'b0;
          end
        end else if (sync_all) begin
          // sync acts as a wrap whose phase-0 cycle is this edge
          ctr    <= CNT_W'(1);
          clk_q  <= 1'b1;
          tick_q <= 1'b1;
          if (pf) begin
            per <= per_n;
            pf  <= 1'b0;
          end
        end else begin
          clk_q  <= (ctr < hi_len);
          tick_q <= (ctr == '0);
          if (ctr >= per - CNT_W'(1)) begin
            ctr <= '0;
            if (pf) begin
              per <= per_n;
              pf  <= 1'b0;
            end
          end else begin
            ctr <= ctr + CNT_W'(1);
          end
        end
        // A write on a wrap edge lands after the wrap consumed the old pending value.
        if (wr_hit) begin
          per_n <= div_data;
          pf    <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: 3-channel build with a short default divisor.
module tb_clk_divider_bank;
  localparam int NCH   = 3;
  localparam int CW    = 27;
  localparam int DDIV  = 20;
  localparam int SW    = 2;

  logic           CLK100MHZ = 1'b0;
  logic           RESET     = 1'b1;
  logic [NCH-1:0] ch_en     = '0;
  logic           div_wr    = 1'b0;
  logic [SW-1:0]  div_sel   = '0;
  logic [CW-1:0]  div_data  = '0;
  logic           sync_all  = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic           wr_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [NCH-1:0] hist_clk  [0:63];
  logic [NCH-1:0] hist_tick [0:63];
  int hidx;

  clk_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RESET     (RESET),
    .ch_en     (ch_en),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_data  (div_data),
    .sync_all  (sync_all),
    .clk_out   (clk_out),
    .tick      (tick),
    .wr_err    (wr_err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic rec();
    step();
    hist_clk[hidx]  = clk_out;
    hist_tick[hidx] = tick;
    hidx++;
  endtask

  task automatic rec_n(input int n);
    for (int k = 0; k < n; k++) rec();
  endtask

  function automatic logic [63:0] pat(input int ch, input bit use_tick, input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n; k++)
      v = {v[62:0], use_tick ? hist_tick[k][ch] : hist_clk[k][ch]};
    return v;
  endfunction

  task automatic write_div(input int sel, input int val);
    div_wr   = 1'b1;
    div_sel  = SW'(sel);
    div_data = CW'(val);
    step();
    div_wr   = 1'b0;
  endtask

  initial begin
    int coin;
    int found;

    // reset state
    step(); step();
    check_eq("reset_clk", clk_out, 0);
    check_eq("reset_tick", tick, 0);
    check_eq("reset_err", wr_err, 0);

    // defaults: P=20 -> 10 high / 10 low, tick at each rise
    RESET = 1'b0;
    ch_en = 3'b111;
    hidx = 0; rec_n(40);
    check_eq("def_clk0", pat(0, 0, 40), 40'hFFC00FFC00);
    check_eq("def_tick0", pat(0, 1, 40), 40'h8000080000);
    check_eq("def_clk2", pat(2, 0, 40), 40'hFFC00FFC00);

    // min and odd divisors, written while disabled
    ch_en = 3'b000;
    step();
    check_eq("dis_clk", clk_out, 0);
    write_div(0, 2);
    write_div(1, 5);
    step();
    check_eq("wr_ok_err", wr_err, 0);
    ch_en = 3'b011;
    hidx = 0; rec_n(10);
    check_eq("p2_clk", pat(0, 0, 10), 10'b1010101010);
    check_eq("p2_tick", pat(0, 1, 10), 10'b1010101010);
    check_eq("p5_clk", pat(1, 0, 10), 10'b1110011100);
    check_eq("p5_tick", pat(1, 1, 10), 10'b1000010000);
    check_eq("p_dis_ch2", pat(2, 0, 10), 0);

    // glitch-free change on ch2: P=10, write 4 at ctr=3
    ch_en = 3'b000;
    write_div(2, 10);
    step();
    ch_en = 3'b100;
    hidx = 0; rec_n(3);
    div_wr = 1'b1; div_sel = 2'd2; div_data = CW'(4);
    rec();
    div_wr = 1'b0;
    rec_n(14);
    check_eq("chg_clk", pat(2, 0, 18), 18'b111110000011001100);
    check_eq("chg_tick", pat(2, 1, 18), 18'b100000000010001000);
    // two writes before the wrap: last one wins
    hidx = 0;
    div_wr = 1'b1; div_data = CW'(6);
    rec();
    div_data = CW'(8);
    rec();
    div_wr = 1'b0;
    rec_n(11);
    check_eq("last_clk", pat(2, 0, 13), 13'b1100111100001);
    check_eq("last_tick", pat(2, 1, 13), 13'b1000100000001);

    // enable/disable on ch1 (P=5)
    ch_en = 3'b110;
    hidx = 0; rec_n(2);
    ch_en = 3'b100;
    rec_n(3);
    ch_en = 3'b110;
    rec_n(6);
    check_eq("en_clk1", pat(1, 0, 11), 11'b11000111001);
    check_eq("en_tick1", pat(1, 1, 11), 11'b10000100001);

    // sync_all with P=4, 6, 10 at staggered phases
    ch_en = 3'b000;
    write_div(0, 4);
    write_div(1, 6);
    write_div(2, 10);
    step();
    ch_en = 3'b001; step();
    ch_en = 3'b011; step(); step();
    ch_en = 3'b111; step(); step(); step();
    sync_all = 1'b1;
    hidx = 0; rec();
    sync_all = 1'b0;
    rec_n(60);
    check_eq("sync_clk", hist_clk[0], 3'b111);
    check_eq("sync_tick", hist_tick[0], 3'b111);
    check_eq("sync_p4", pat(0, 0, 13), 13'b1100110011001);
    check_eq("sync_p6", pat(1, 0, 13), 13'b1110001110001);
    check_eq("sync_p10", pat(2, 0, 11), 11'b11111000001);
    check_eq("sync_12", hist_tick[12], 3'b011);
    check_eq("sync_60", hist_tick[60], 3'b111);
    coin = 0;
    for (int k = 1; k < 60; k++) if (hist_tick[k] == 3'b111) coin++;
    check_eq("sync_no_early", coin, 0);

    // rejected writes
    div_wr = 1'b1; div_sel = 2'd0; div_data = CW'(1);
    step();
    check_eq("err_small", wr_err, 1);
    div_sel = 2'd3; div_data = CW'(7);
    step();
    check_eq("err_sel", wr_err, 1);
    div_wr = 1'b0;
    step();
    check_eq("err_clear", wr_err, 0);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      if (tick[0]) found = 1;
    end
    check_eq("err_tick_seen", found, 1);
    hidx = 0; rec_n(8);
    check_eq("err_p_kept", pat(0, 1, 8), 8'b00010001);

    // reset discards a pending write
    write_div(0, 3);
    RESET = 1'b1;
    step();
    check_eq("rst_clk", clk_out, 0);
    check_eq("rst_tick", tick, 0);
    RESET = 1'b0;
    hidx = 0; rec_n(21);
    check_eq("rst_def_p", pat(0, 0, 21), {10'h3FF, 10'h000, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_divider_bank.md
Name: clk_divider_bank

Overview:
Bank of NUM_CH independent, runtime-programmable clock dividers driven from the 100 MHz board clock. It is the generalised successor to the fixed per-frequency divider modules. Each channel produces a square-wave clock output and a one-cycle tick strobe, with these features:
- divisor loadable at runtime, with glitch-free changeover at period boundaries
- per-channel enable
- global phase-align pulse

Outputs feed LEDs, PMOD pins and downstream logic as clock enables.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 27, counter/divisor width in bits; 27 covers divide-by-100_000_000 (1 Hz)
DEFAULT_DIV, 100_000, divisor loaded into every channel at reset (1 kHz); must be >=2 and <2^CNT_W
SEL_W (localparam), max(1, clog2(NUM_CH)), channel-select width

Ports:
CLK100MHZ  input  1  system clock, 100 MHz, all logic on rising edge
RESET  input  1  synchronous, active-high reset
ch_en  input  NUM_CH  per-channel run enable, level
div_wr  input  1  single-cycle divisor write strobe
div_sel  input  SEL_W  target channel for div_wr
div_data  input  CNT_W  new divisor P (input cycles per output period)
sync_all  input  1  single-cycle pulse; restarts all enabled channels at phase 0
clk_out  output  NUM_CH  registered divided clock per channel
tick  output  NUM_CH  registered one-cycle pulse per channel, coincident with each clk_out rising edge
wr_err  output  1  registered one-cycle pulse on a rejected write

Behaviour:
- Per-channel state: ctr[CNT_W], period P[CNT_W], pending value Pn[CNT_W], pending flag pf.
- Derived phase lengths: H = P - floor(P/2) (high phase); L = floor(P/2) (low phase). Output period is exactly P input cycles. Duty is 50% for even P; odd P is high one cycle longer than low.
- RESET (highest priority, synchronous): every channel gets ctr=0, P=DEFAULT_DIV, pf=0; clk_out=0, tick=0, wr_err=0.
- Enabled channel, each edge, in priority order:
  1. If sync_all: ctr<=1; clk_out<=1; tick<=1; if pf then P<=Pn and pf<=0. sync_all is treated as a wrap; next cycles follow the new P.
  2. Else: clk_out<=(ctr<H); tick<=(ctr==0); ctr<=(ctr==P-1)?0:ctr+1.
  3. At the wrap edge (ctr==P-1), if pf then P<=Pn and pf<=0. The new period starts with the next clk_out rise, so there are no runt pulses.
- First edge after reset or enable: clk_out and tick rise together; there is no partial first period.
- Disabled channel (ch_en=0): ctr<=0, clk_out<=0, tick<=0. Any pending divisor is applied immediately (P<=Pn, pf<=0). Re-enable starts at phase 0 per rule 2.
- Divisor write (div_wr=1):
  - Accepted iff div_data>=2 and div_sel<NUM_CH: Pn<=div_data, pf<=1.
  - Otherwise: no state change, and wr_err pulses high the following cycle.
  - Multiple writes before a wrap: last one wins.
  - Write on the same edge as a wrap or sync_all: the wrap/sync uses the previous pending state; the new value applies at the following wrap.
  - Write to a disabled channel: applies on the next edge while it stays disabled.
- Output latency: clk_out and tick are registers; no combinational path from any input to any output.
- Channels are fully independent except for sync_all, which aligns all enabled channels. Disabled channels ignore sync_all.
- Counter never exceeds P-1. A decrease of P is deferred to the wrap, so ctr>=P cannot occur.

Test Plan:
1. Reset defaults: RESET 2 cycles, ch_en=all 1 → each clk_out high 50_000 / low 50_000 cycles; tick every 100_000 cycles, aligned with the clk_out rise; first rise one edge after ch_en seen.
2. Min and odd divisors: write P=2 to ch0 and P=5 to ch1 while disabled, then enable → ch0 toggles every cycle (50 MHz), tick every 2 cycles; ch1 pattern 1,1,1,0,0 repeating.
3. Glitch-free change: ch2 running P=10; write P=4 at ctr=3 → current period completes (5 high, 5 low), then 2 high/2 low; no pulse shorter than 2 cycles. Write P=6 then P=8 before the wrap → P=8 used.
4. Enable/disable: drop ch_en[1] mid-high phase → clk_out[1]=0 next edge and holds; reassert → rises next edge with a full H-cycle high phase.
5. sync_all: channels at P=4, P=6, P=10 with arbitrary phase; pulse sync_all → all clk_out and tick high on the same edge; rises coincide again after 12 cycles (P=4/P=6) and 60 cycles (all three).
6. Errors and reset: write div_data=1, then div_sel=NUM_CH (NUM_CH=3 build) → wr_err one-cycle pulse each, no period change. Assert RESET with a pending write → pending discarded, P=DEFAULT_DIV, all outputs 0 next edge.
